// File: rtl/truth_table_sequencer.sv
// Exhaustive input sweep of an N_IN-input, 1-output function unit; captures its truth table
// and compares it against an expected table latched at start.
module truth_table_sequencer #(
  parameter int unsigned N_IN          = 4,
  parameter int unsigned SETTLE_CYCLES = 2,
  localparam int unsigned T            = 1 << N_IN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [T-1:0]    exp_tt,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_f,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [T-1:0]    captured_tt,
  output logic [T-1:0]    mismatch,
  output logic [N_IN:0]   err_count
);

  localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

  state_e          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [T-1:0]    exp_q, exp_d;
  logic [T-1:0]    cap_q, cap_d;
  logic [T-1:0]    mis_q, mis_d;
  logic [N_IN:0]   err_q, err_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;

  logic settle_last;
  logic idx_last;

  assign settle_last = (cnt_q == CW'(SETTLE_CYCLES - 1));
  assign idx_last    = (idx_q == N_IN'(T - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      cap_q   <= '0;
      mis_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      cap_q   <= cap_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start && !abort) state_d = StSettle;
      StSettle: begin
        if (abort)            state_d = StIdle;
        else if (settle_last) state_d = StSample;
      end
      StSample: begin
        if (abort)         state_d = StIdle;
        else if (idx_last) state_d = StDone;
        else               state_d = StSettle;
      end
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    exp_d  = exp_q;
    cap_d  = cap_q;
    mis_d  = mis_q;
    err_d  = err_q;
    busy_d = busy_q;
    done_d = 1'b0;
    pass_d = pass_q;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          exp_d  = exp_tt;
          cap_d  = '0;
          mis_d  = '0;
          err_d  = '0;
          pass_d = 1'b0;
          idx_d  = '0;
          cnt_d  = '0;
          busy_d = 1'b1;
        end
      end
      StSettle: begin
        if (abort) begin
          busy_d = 1'b0;
          idx_d  = '0;
          cnt_d  = '0;
        end else if (!settle_last) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StSample: begin
        if (abort) begin
          busy_d = 1'b0;
          idx_d  = '0;
          cnt_d  = '0;
        end else begin
          cap_d[idx_q] = dut_f;
          mis_d[idx_q] = dut_f ^ exp_q[idx_q];
          if (dut_f ^ exp_q[idx_q]) err_d = err_q + (N_IN + 1)'(1);
          if (idx_last) begin
            // Verdict uses err_d so the final vector's miss is counted.
            busy_d = 1'b0;
            done_d = 1'b1;
            pass_d = (err_d == '0);
          end else begin
            idx_d = idx_q + N_IN'(1);
            cnt_d = '0;
          end
        end
      end
      StDone: begin
        idx_d = '0;
        cnt_d = '0;
      end
      default: ;
    endcase
  end

  assign dut_in      = idx_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign captured_tt = cap_q;
  assign mismatch    = mis_q;
  assign err_count   = err_q;

endmodule

// File: doc/truth_table_sequencer.md
Name: truth_table_sequencer

Overview:
Controller that drives an exhaustive input sweep into a combinational N_IN-input, 1-output function unit, such as the 4-input a,b,c,d -> f logic blocks in the lab set. It applies every input vector in ascending order and waits a settle time before sampling the output. It builds the captured truth table, compares it bit-by-bit against an expected table, and reports pass/fail through a start/done handshake. It replaces hand-written per-vector stimulus with a synthesizable self-check sequencer placed beside the function unit.

Parameters:
N_IN, 4, number of function-unit inputs; table width T = 2**N_IN
SETTLE_CYCLES, 2, clocks each vector is held before sampling; legal range >= 1

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin sweep; accepted only in IDLE
abort  input  1  cancel sweep in progress
exp_tt  input  T  expected truth table; bit k = expected f for input vector k; latched on start acceptance
dut_in  output  N_IN  vector driven to function unit; MSB = first input (a), LSB = last (d)
dut_f  input  1  function unit output
busy  output  1  high from start acceptance until DONE is entered
done  output  1  one-cycle pulse at sweep completion
pass  output  1  high when last completed sweep had zero mismatches; held until next start
captured_tt  output  T  sampled dut_f per vector
mismatch  output  T  bit k = captured_tt[k] XOR latched exp_tt[k]
err_count  output  N_IN+1  number of set bits in mismatch

Behaviour:
- All outputs are registered. Reset applies on a clk edge with rst=1, overrides all other inputs, and can interrupt a sweep. Reset clears the state to IDLE and sets dut_in, busy, done, pass, captured_tt, mismatch, err_count, the index and the settle counter to 0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: on an edge with start=1 and abort=0:
  - latch exp_tt
  - clear captured_tt, mismatch, err_count and pass
  - set idx=0, dut_in=0, cnt=0, busy=1
  - go to SETTLE
- If start=1 and abort=1 together in IDLE, abort wins and start is ignored.
- SETTLE: dut_in holds idx. cnt increments each cycle. When cnt==SETTLE_CYCLES-1, go to SAMPLE, so SETTLE lasts exactly SETTLE_CYCLES cycles.
- SAMPLE: one cycle. On the exiting edge:
  - captured_tt[idx] <= dut_f
  - mismatch[idx] <= dut_f ^ exp_latched[idx]
  - err_count increments by 1 if the bits differ
- Leaving SAMPLE: if idx==T-1, go to DONE. Otherwise idx and dut_in increment, cnt=0, and the state returns to SETTLE.
- Vector k is sampled on edge (k+1)*(SETTLE_CYCLES+1) after the accepting edge.
- DONE: lasts one cycle with done=1 and busy=0. pass <= (final err_count == 0), including the last vector's contribution. Then go unconditionally to IDLE; done returns to 0.
- done first reads high after edge T*(SETTLE_CYCLES+1) following the accepting edge: edge 48 for the defaults.
- start during SETTLE, SAMPLE or DONE is ignored. No queuing.
- abort in SETTLE or SAMPLE: the next edge goes to IDLE with busy=0 and dut_in=0, and done is not pulsed. pass stays 0. Partial captured_tt, mismatch and err_count are retained until the next start. No sample is taken on an aborted SAMPLE edge. abort in IDLE or DONE has no effect.
- dut_in is 0 in IDLE and never exceeds T-1. idx does not wrap.
- err_count saturation is never needed; its maximum is T, which fits in N_IN+1 bits.

Test Plan:
- Function unit f=(a&b)|(c&~d), exp_tt=16'hF444, pulse start -> dut_in steps 0..15, holding each value 3 cycles; done pulses once, 48 cycles after acceptance; captured_tt=16'hF444, mismatch=0, err_count=0, pass=1.
- Same unit, exp_tt=16'hF445 -> mismatch=16'h0001, err_count=1, pass=0, captured_tt=16'hF444.
- Same unit, exp_tt=16'h0BBB (full inversion) -> mismatch=16'hFFFF, err_count=16, pass=0.
- Assert abort while dut_in=5 in SETTLE -> next cycle IDLE, busy=0, dut_in=0, no done pulse; captured_tt bits 0..4 valid and bits above 4 are 0. A following start gives a full correct sweep.
- Pulse start again during a sweep at dut_in=7 -> ignored; sweep timing unchanged. Assert start and abort together in IDLE -> remains IDLE.
- Assert rst for 1 cycle at dut_in=9 -> all outputs 0 and IDLE on the next edge. A later start completes normally with pass=1.
